store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 170 +++++++++++++++++
 tb/tb_store_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Four-entry write-back store buffer sitting between the CPU and data_mem.
// Define STORE_FWD_EN to forward pending store data to matching loads instead of stalling them.
module store_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_write,
    input  logic        cpu_read,
    input  logic        flush,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        flush_done,
    output logic        full,
    output logic        empty,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    typedef enum logic {RUN, FLUSH} state_t;

    logic [31:0] addr_q [4];
    logic [31:0] addr_d [4];
    logic [31:0] data_q [4];
    logic [31:0] data_d [4];
    logic [3:0]  valid_q, valid_d;
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic [2:0]  count_q, count_d;
    state_t      state_q, state_d;
    logic        flush_done_q, flush_done_d;

    logic        hit;
    logic        hit_stall;
    logic        load_req;
    logic        load_miss;
    logic        drain;
    logic        enq;
`ifdef STORE_FWD_EN
    logic [31:0] fwd_data;
`endif

    assign full       = (count_q == 3'd4);
    assign empty      = (count_q == 3'd0);
    assign flush_done = flush_done_q;

    // Walk entries oldest to youngest so the last match seen is the youngest store.
    always_comb begin : lookup_proc
        logic [1:0] idx;
        idx = '0;
        hit = 1'b0;
`ifdef STORE_FWD_EN
        fwd_data = '0;
`endif
        for (int k = 0; k < 4; k++) begin
            idx = head_q + 2'(k);
            if (valid_q[idx] && (addr_q[idx] == cpu_addr)) begin
                hit = 1'b1;
`ifdef STORE_FWD_EN
                fwd_data = data_q[idx];
`endif
            end
        end
    end

    always_comb begin
        load_req  = cpu_read && (state_q == RUN);
        load_miss = load_req && !hit;
        drain     = (count_q != 3'd0) && !load_miss;
        enq       = cpu_write && !cpu_read && (state_q == RUN) && !full;
`ifdef STORE_FWD_EN
        hit_stall = 1'b0;
`else
        hit_stall = hit;
`endif

        cpu_stall      = 1'b0;
        cpu_rdata      = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;

        if (state_q == FLUSH)
            cpu_stall = cpu_read || cpu_write;
        else if (cpu_read)
            cpu_stall = cpu_write || hit_stall;
        else
            cpu_stall = cpu_write && full;

        // A missing load owns the memory port; otherwise the head entry drains.
        if (load_miss) begin
            mem_read    = 1'b1;
            mem_address = cpu_addr;
            cpu_rdata   = mem_read_data;
        end else if (drain) begin
            mem_write      = 1'b1;
            mem_address    = addr_q[head_q];
            mem_write_data = data_q[head_q];
        end
`ifdef STORE_FWD_EN
        if (load_req && hit)
            cpu_rdata = fwd_data;
`endif
    end

    always_comb begin
        addr_d       = addr_q;
        data_d       = data_q;
        valid_d      = valid_q;
        head_d       = head_q;
        tail_d       = tail_q;
        state_d      = state_q;
        flush_done_d = 1'b0;

        if (enq) begin
            addr_d[tail_q]  = cpu_addr;
            data_d[tail_q]  = cpu_wdata;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 2'd1;
        end
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 2'd1;
        end
        count_d = count_q + 3'(enq) - 3'(drain);

        case (state_q)
            RUN: begin
                if (flush)
                    state_d = FLUSH;
            end
            FLUSH: begin
                if (count_d == 3'd0) begin
                    state_d      = RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= RUN;
            flush_done_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, then random traffic against a queue model.
module tb_store_buffer;

`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_write;
    logic        cpu_read;
    logic        flush;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        flush_done;
    logic        full;
    logic        empty;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    logic [31:0] dmem [256] = '{default: 32'h0};
    logic [31:0] ref_mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_read_data = dmem[mem_address[9:2]];

    always @(posedge clk) begin
        if (mem_write)
            dmem[mem_address[9:2]] <= mem_write_data;
    end

    store_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_write      (cpu_write),
        .cpu_read       (cpu_read),
        .flush          (flush),
        .cpu_rdata      (cpu_rdata),
        .cpu_stall      (cpu_stall),
        .flush_done     (flush_done),
        .full           (full),
        .empty          (empty),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic        rd;
        logic        fl;
        logic        e_stall;
        logic [31:0] e_rdata;
        logic        e_mw;
        logic        e_mr;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_empty;
        logic        e_fd;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [31:0] a, logic [31:0] wd, logic w, logic rd, logic f,
                                logic st, logic [31:0] rdat, logic mw, logic mr,
                                logic [31:0] ma, logic [31:0] mwd, logic em, logic fd);
        vec_t v;
        v.rst = r; v.addr = a; v.wdata = wd; v.wr = w; v.rd = rd; v.fl = f;
        v.e_stall = st; v.e_rdata = rdat; v.e_mw = mw; v.e_mr = mr;
        v.e_maddr = ma; v.e_mwdata = mwd; v.e_empty = em; v.e_fd = fd;
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic [31:0] a, input logic [31:0] wd,
                                 input logic w, input logic rd, input logic f);
        @(negedge clk);
        rst = r; cpu_addr = a; cpu_wdata = wd; cpu_write = w; cpu_read = rd; flush = f;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic st, input logic [31:0] rdat, input logic mw,
                            input logic mr, input logic [31:0] ma, input logic [31:0] mwd,
                            input logic em, input logic fu, input logic fd);
        checkOutput({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(st));
        checkOutput({tag, ".cpu_rdata"}, cpu_rdata, rdat);
        checkOutput({tag, ".mem_write"}, 32'(mem_write), 32'(mw));
        checkOutput({tag, ".mem_read"}, 32'(mem_read), 32'(mr));
        checkOutput({tag, ".mem_address"}, mem_address, ma);
        checkOutput({tag, ".mem_write_data"}, mem_write_data, mwd);
        checkOutput({tag, ".empty"}, 32'(empty), 32'(em));
        checkOutput({tag, ".full"}, 32'(full), 32'(fu));
        checkOutput({tag, ".flush_done"}, 32'(flush_done), 32'(fd));
    endtask

    initial begin
        ent_t        q[$];
        logic        m_flushing;
        logic        m_done;
        logic        r, w, rd, f;
        logic [31:0] a, wd;
        logic        running, hit, miss, drn, was_full, e_st;
        logic [31:0] fwd, e_rd, e_ma, e_wd;
        logic [31:0] chk_addr;
        ent_t        ne;

        rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_write = 1'b0; cpu_read = 1'b0; flush = 1'b0;

        // Directed sequence from reset; expectations derived by hand.
        vecs.push_back(mk(0, 32'h000, 32'h00, 0, 0, 0,  0, 32'h0, 0, 0, 32'h000, 32'h00, 1, 0));
        vecs.push_back(mk(0, 32'h100, 32'h11, 1, 0, 0,  0, 32'h0, 0, 0, 32'h000, 32'h00, 1, 0));
        vecs.push_back(mk(0, 32'h104, 32'h22, 1, 0, 0,  0, 32'h0, 1, 0, 32'h100, 32'h11, 0, 0));
        vecs.push_back(mk(0, 32'h108, 32'h33, 1, 0, 0,  0, 32'h0, 1, 0, 32'h104, 32'h22, 0, 0));
        vecs.push_back(mk(0, 32'h10C, 32'h44, 1, 0, 0,  0, 32'h0, 1, 0, 32'h108, 32'h33, 0, 0));
        vecs.push_back(mk(0, 32'h110, 32'h55, 1, 0, 0,  0, 32'h0, 1, 0, 32'h10C, 32'h44, 0, 0));
        vecs.push_back(mk(0, 32'h000, 32'h00, 0, 0, 0,  0, 32'h0, 1, 0, 32'h110, 32'h55, 0, 0));
        vecs.push_back(mk(0, 32'h000, 32'h00, 0, 0, 0,  0, 32'h0, 0, 0, 32'h000, 32'h00, 1, 0));
        vecs.push_back(mk(0, 32'h100, 32'h00, 0, 1, 0,  0, 32'h11, 0, 1, 32'h100, 32'h00, 1, 0));
        vecs.push_back(mk(0, 32'h040, 32'hDEADBEEF, 1, 0, 0,  0, 32'h0, 0, 0, 32'h000, 32'h0, 1, 0));
        vecs.push_back(mk(0, 32'h040, 32'h12345678, 1, 0, 0,  0, 32'h0, 1, 0, 32'h040, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 32'h040, 32'h0, 0, 1, 0,  !FWD, FWD ? 32'h12345678 : 32'h0, 1, 0,
                          32'h040, 32'h12345678, 0, 0));
        vecs.push_back(mk(0, 32'h040, 32'h0, 0, 1, 0,  0, 32'h12345678, 0, 1, 32'h040, 32'h0, 1, 0));
        vecs.push_back(mk(0, 32'h100, 32'h99, 1, 1, 0,  1, 32'h11, 0, 1, 32'h100, 32'h00, 1, 0));
        vecs.push_back(mk(0, 32'h000, 32'h00, 0, 0, 0,  0, 32'h0, 0, 0, 32'h000, 32'h00, 1, 0));
        vecs.push_back(mk(0, 32'h200, 32'hAA, 1, 0, 0,  0, 32'h0, 0, 0, 32'h000, 32'h00, 1, 0));
        vecs.push_back(mk(0, 32'h204, 32'hBB, 1, 0, 1,  0, 32'h0, 1, 0, 32'h200, 32'hAA, 0, 0));
        vecs.push_back(mk(0, 32'h208, 32'hCC, 1, 0, 0,  1, 32'h0, 1, 0, 32'h204, 32'hBB, 0, 0));
        vecs.push_back(mk(0, 32'h000, 32'h00, 0, 0, 0,  0, 32'h0, 0, 0, 32'h000, 32'h00, 1, 1));
        vecs.push_back(mk(0, 32'h000, 32'h00, 0, 0, 0,  0, 32'h0, 0, 0, 32'h000, 32'h00, 1, 0));
        vecs.push_back(mk(0, 32'h300, 32'hDD, 1, 0, 0,  0, 32'h0, 0, 0, 32'h000, 32'h00, 1, 0));
        vecs.push_back(mk(1, 32'h100, 32'h00, 0, 1, 0,  0, 32'h11, 0, 1, 32'h100, 32'h00, 0, 0));
        vecs.push_back(mk(0, 32'h000, 32'h00, 0, 0, 0,  0, 32'h0, 0, 0, 32'h000, 32'h00, 1, 0));
        vecs.push_back(mk(0, 32'h000, 32'h00, 0, 0, 1,  0, 32'h0, 0, 0, 32'h000, 32'h00, 1, 0));
        vecs.push_back(mk(0, 32'h000, 32'h00, 0, 0, 0,  0, 32'h0, 0, 0, 32'h000, 32'h00, 1, 0));
        vecs.push_back(mk(0, 32'h104, 32'h00, 0, 1, 0,  0, 32'h22, 0, 1, 32'h104, 32'h00, 1, 1));
        vecs.push_back(mk(0, 32'h000, 32'h00, 0, 0, 0,  0, 32'h0, 0, 0, 32'h000, 32'h00, 1, 0));

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].addr, vecs[i].wdata, vecs[i].wr, vecs[i].rd, vecs[i].fl);
            checkAll($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_rdata, vecs[i].e_mw, vecs[i].e_mr,
                     vecs[i].e_maddr, vecs[i].e_mwdata, vecs[i].e_empty, 1'b0, vecs[i].e_fd);
        end

        // Memory image after the directed sequence: five streamed stores, flushed store, discarded ones.
        for (int i = 0; i < 5; i++) begin
            chk_addr = 32'h100 + 32'(4 * i);
            checkOutput($sformatf("dmem_0x%0h", chk_addr), dmem[chk_addr[9:2]], 32'h11 * 32'(i + 1));
        end
        checkOutput("dmem_0x204", dmem[8'h81], 32'hBB);
        checkOutput("dmem_0x208_refused", dmem[8'h82], 32'h0);
        checkOutput("dmem_0x300_discarded", dmem[8'hC0], 32'h0);

        // Random traffic against a queue-based model; restart from reset for a known start.
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) ref_mem[i] = dmem[i];
        q.delete();
        m_flushing = 1'b0;
        m_done = 1'b0;

        for (int c = 0; c < 600; c++) begin
            r  = ($urandom_range(0, 59) == 0);
            w  = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 2) == 0);
            f  = ($urandom_range(0, 15) == 0);
            a  = 32'h40 + 32'($urandom_range(0, 5) * 4);
            wd = $urandom;
            applyStimulus(r, a, wd, w, rd, f);

            running = !m_flushing;
            hit = 1'b0;
            fwd = '0;
            foreach (q[k]) begin
                if (q[k].a == a) begin
                    hit = 1'b1;
                    fwd = q[k].d;
                end
            end
            miss     = rd && running && !hit;
            drn      = (q.size() > 0) && !miss;
            was_full = (q.size() == 4);
            if (!running)  e_st = rd || w;
            else if (rd)   e_st = w || (hit && !FWD);
            else           e_st = w && was_full;
            e_rd = '0; e_ma = '0; e_wd = '0;
            if (miss) begin
                e_rd = ref_mem[a[9:2]];
                e_ma = a;
            end else if (drn) begin
                e_ma = q[0].a;
                e_wd = q[0].d;
            end
            if (FWD && rd && running && hit) e_rd = fwd;

            checkAll($sformatf("rnd%0d", c), e_st, e_rd, drn, miss, e_ma, e_wd,
                     q.size() == 0, was_full, m_done);

            if (drn) begin
                ref_mem[q[0].a[9:2]] = q[0].d;
                void'(q.pop_front());
            end
            if (r) begin
                q.delete();
                m_flushing = 1'b0;
                m_done = 1'b0;
            end else begin
                m_done = 1'b0;
                if (w && !rd && running && !was_full) begin
                    ne.a = a;
                    ne.d = wd;
                    q.push_back(ne);
                end
                if (running && f) begin
                    m_flushing = 1'b1;
                end else if (!running && q.size() == 0) begin
                    m_flushing = 1'b0;
                    m_done = 1'b1;
                end
            end
        end

        @(negedge clk);
        for (int i = 16; i < 24; i++)
            checkOutput($sformatf("rnd_dmem[%0d]", i), dmem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
